// File: rtl/keypad_matrix_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_matrix_emulator
//  Description : Emulates a 4x4 push-button matrix. Queued key presses are
//                played out as timed contacts with optional press/release
//                bounce and an inter-key gap; row lines answer the scanner's
//                active-low column strobes combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_emulator #(
    parameter int HOLD_W        = 16,
    parameter int BOUNCE_CYCLES = 8,
    parameter int BOUNCE_PERIOD = 2,
    parameter int GAP_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              cancel,
    output logic              busy,
    output logic              contact,
    output logic              done
);

    // Degenerate parameter values are clamped to their legal minimum.
    localparam int c_GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int c_BP_EFF  = (BOUNCE_PERIOD < 1) ? 1 : BOUNCE_PERIOD;
    localparam int c_LEN_MAX = (BOUNCE_CYCLES > c_GAP_EFF) ? BOUNCE_CYCLES : c_GAP_EFF;
    localparam int c_LEN_W   = $clog2(c_LEN_MAX + 1);
    localparam int c_CNT_W   = (HOLD_W > c_LEN_W) ? HOLD_W : c_LEN_W;

    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_BOUNCE_LAST = c_CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST    = c_CNT_W'(c_GAP_EFF - 1);
    localparam logic [c_CNT_W-1:0] c_PERIOD      = c_CNT_W'(c_BP_EFF);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_PBOUNC = 3'd1;
    localparam logic [2:0] c_S_HOLD   = 3'd2;
    localparam logic [2:0] c_S_RBOUNC = 3'd3;
    localparam logic [2:0] c_S_GAP    = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_key;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_contact;
    logic               r_done;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_elapsed;
    logic [HOLD_W-1:0]  w_hold_eff;
    logic               w_accept;
    logic               w_last;
    logic               w_half_odd;
    logic               w_contact_nxt;
    logic               w_done_nxt;

    assign w_accept   = req_valid && (r_state == c_S_IDLE);
    assign w_last     = (r_cnt == '0);
    assign w_hold_eff = (req_hold == '0) ? HOLD_W'(1) : req_hold;

    // Next state and counter reload; the counter counts down to zero in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - c_ONE;
        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (w_accept) begin
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_nxt = c_S_PBOUNC;
                        w_cnt_nxt   = c_BOUNCE_LAST;
                    end else begin
                        w_state_nxt = c_S_HOLD;
                        w_cnt_nxt   = c_CNT_W'(w_hold_eff) - c_ONE;
                    end
                end
            end
            c_S_PBOUNC: begin
                if (cancel) begin
                    w_state_nxt = c_S_GAP;
                    w_cnt_nxt   = c_GAP_LAST;
                end else if (w_last) begin
                    w_state_nxt = c_S_HOLD;
                    w_cnt_nxt   = c_CNT_W'(r_hold) - c_ONE;
                end
            end
            c_S_HOLD: begin
                if (cancel) begin
                    w_state_nxt = c_S_GAP;
                    w_cnt_nxt   = c_GAP_LAST;
                end else if (w_last) begin
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_nxt = c_S_RBOUNC;
                        w_cnt_nxt   = c_BOUNCE_LAST;
                    end else begin
                        w_state_nxt = c_S_GAP;
                        w_cnt_nxt   = c_GAP_LAST;
                    end
                end
            end
            c_S_RBOUNC: begin
                if (cancel || w_last) begin
                    w_state_nxt = c_S_GAP;
                    w_cnt_nxt   = c_GAP_LAST;
                end
            end
            c_S_GAP: begin
                if (w_last) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Contact level for the coming cycle, derived from where the sequence will be.
    always_comb begin
        w_elapsed     = c_BOUNCE_LAST - w_cnt_nxt;
        w_half_odd    = ((w_elapsed / c_PERIOD) & c_ONE) != '0;
        w_contact_nxt = 1'b0;
        case (w_state_nxt)
            c_S_PBOUNC: w_contact_nxt = !w_half_odd;
            c_S_HOLD:   w_contact_nxt = 1'b1;
            c_S_RBOUNC: w_contact_nxt = w_half_odd;
            default:    w_contact_nxt = 1'b0;
        endcase
        w_done_nxt = (r_state == c_S_GAP) && w_last;
    end

    // Sequence registers; reset opens the contact immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_key     <= '0;
            r_hold    <= '0;
            r_contact <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_contact <= w_contact_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_key  <= req_key;
                r_hold <= w_hold_eff;
            end
        end
    end

    // Row answer: only the latched key's column strobe is examined.
    always_comb begin
        row = 4'hF;
        if (r_contact && !col[r_key[3:2]]) begin
            row[r_key[1:0]] = 1'b0;
        end
    end

    assign req_ready = (r_state == c_S_IDLE);
    assign busy      = (r_state != c_S_IDLE);
    assign contact   = r_contact;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_matrix_emulator
//  Description : Self-checking bench for keypad_matrix_emulator. One default
//                instance and one bounce-free instance are compared against
//                a contact-sequence model built from the press timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_emulator;

    localparam int c_HOLD_W = 16;
    localparam int c_BC     = 8;
    localparam int c_BP     = 2;
    localparam int c_GAP    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  key;
    logic [15:0] hold;
    logic        cancel;
    logic        sel;
    logic        v0, v1;
    logic [3:0]  row0, row1;
    logic        rdy0, rdy1, busy0, busy1, ct0, ct1, dn0, dn1;

    logic [3:0]  row_s;
    logic        rdy_s, busy_s, ct_s, dn_s;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    keypad_matrix_emulator #(
        .HOLD_W(c_HOLD_W), .BOUNCE_CYCLES(c_BC), .BOUNCE_PERIOD(c_BP), .GAP_CYCLES(c_GAP)
    ) u_dut_bounce (
        .clk(clk), .reset(reset), .col(col), .row(row0),
        .req_valid(v0), .req_ready(rdy0), .req_key(key), .req_hold(hold),
        .cancel(cancel), .busy(busy0), .contact(ct0), .done(dn0)
    );

    keypad_matrix_emulator #(
        .HOLD_W(c_HOLD_W), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(c_BP), .GAP_CYCLES(c_GAP)
    ) u_dut_clean (
        .clk(clk), .reset(reset), .col(col), .row(row1),
        .req_valid(v1), .req_ready(rdy1), .req_key(key), .req_hold(hold),
        .cancel(cancel), .busy(busy1), .contact(ct1), .done(dn1)
    );

    assign row_s  = sel ? row1  : row0;
    assign rdy_s  = sel ? rdy1  : rdy0;
    assign busy_s = sel ? busy1 : busy0;
    assign ct_s   = sel ? ct1   : ct0;
    assign dn_s   = sel ? dn1   : dn0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Contact level for each busy cycle: press bounce, hold, release bounce, gap.
    function automatic void build_seq(input int bc, input int h);
        int he;
        he = (h == 0) ? 1 : h;
        exp_q.delete();
        for (int n = 0; n < bc; n++) exp_q.push_back(((n / c_BP) % 2) == 0);
        for (int n = 0; n < he; n++) exp_q.push_back(1'b1);
        for (int n = 0; n < bc; n++) exp_q.push_back(((n / c_BP) % 2) == 1);
        for (int n = 0; n < c_GAP; n++) exp_q.push_back(1'b0);
    endfunction

    function automatic logic [3:0] rand_col();
        int r;
        logic [3:0] one;
        r = $urandom_range(0, 7);
        one = 4'b0001;
        if (r < 4)      return ~(one << r);
        else if (r < 6) return ~(one << key[3:2]);
        else            return 4'($urandom);
    endfunction

    function automatic logic [3:0] exp_row(input bit c, input logic [3:0] cl, input logic [3:0] k);
        logic [3:0] one;
        one = 4'b0001;
        if (c && !cl[k[3:2]]) return ~(one << k[1:0]);
        return 4'hF;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            col = rand_col(); #1;
            check_val("idle_row0", row0, 4'hF);
            check_val("idle_row1", row1, 4'hF);
            check_val("idle_ready", {rdy0, rdy1}, 2'b11);
            check_val("idle_busy", {busy0, busy1}, 2'b00);
            check_val("idle_done", {dn0, dn1}, 2'b00);
        end
    endtask

    // mode 0: full press, 1: cancel after cycle 'at', 2: async reset in cycle 'at'.
    task automatic press(input bit s, input logic [3:0] k, input int h,
                         input int mode, input int at, input bit keep);
        int n;
        sel = s;
        build_seq(s ? 0 : c_BC, h);
        key  = k;
        hold = h[15:0];
        if (s) v1 = 1'b1; else v0 = 1'b1;
        check_val("ready_pre", rdy_s, 1'b1);
        @(posedge clk); #1;
        if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            col = rand_col(); #1;
            check_val("contact", ct_s, exp_q[i]);
            check_val("row", row_s, exp_row(exp_q[i], col, k));
            check_val("busy", busy_s, 1'b1);
            check_val("ready_busy", rdy_s, 1'b0);
            check_val("done_early", dn_s, 1'b0);
            if (mode == 1 && i + 1 == at) begin
                cancel = 1'b1;
                while (exp_q.size() > i + 1) void'(exp_q.pop_back());
                for (int g = 0; g < c_GAP; g++) exp_q.push_back(1'b0);
                n = exp_q.size();
            end
            if (mode == 2 && i + 1 == at) begin
                col = ~(4'b0001 << k[3:2]);
                #1 reset = 1'b1;
                #1;
                check_val("rst_contact", ct_s, 1'b0);
                check_val("rst_row", row_s, 4'hF);
                check_val("rst_ready", rdy_s, 1'b1);
                check_val("rst_busy", busy_s, 1'b0);
                #1 reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    check_val("post_rst_done", dn_s, 1'b0);
                    check_val("post_rst_ready", rdy_s, 1'b1);
                    check_val("post_rst_contact", ct_s, 1'b0);
                end
                return;
            end
            @(posedge clk); #1;
            cancel = 1'b0;
        end
        col = rand_col(); #1;
        check_val("done_pulse", dn_s, 1'b1);
        check_val("done_ready", rdy_s, 1'b1);
        check_val("done_busy", busy_s, 1'b0);
        check_val("done_contact", ct_s, 1'b0);
        check_val("done_row", row_s, 4'hF);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cyc [4];
        int h, bc, mode, at;
        bit s;
        cyc[0] = 4'b1110; cyc[1] = 4'b1101; cyc[2] = 4'b1011; cyc[3] = 4'b0111;
        reset = 1'b1; col = 4'hF; key = '0; hold = '0; cancel = 1'b0;
        sel = 1'b0; v0 = 1'b0; v1 = 1'b0;
        #1;
        check_val("reset_ready", {rdy0, rdy1}, 2'b11);
        check_val("reset_contact", {ct0, ct1}, 2'b00);
        check_val("reset_busy", {busy0, busy1}, 2'b00);
        check_val("reset_done", {dn0, dn1}, 2'b00);
        #12 reset = 1'b0;

        // Idle with strobes cycling: no row activity.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            col = cyc[i % 4]; #1;
            check_val("idle_scan_row", {row0, row1}, 8'hFF);
            check_val("idle_scan_ready", {rdy0, rdy1}, 2'b11);
            check_val("idle_scan_done", {dn0, dn1}, 2'b00);
        end

        // Directed cases.
        press(1'b1, 4'b0110, 5, 0, 0, 1'b0);
        idle_cycles(2);
        press(1'b0, 4'b0000, 3, 0, 0, 1'b0);
        idle_cycles(1);
        press(1'b0, 4'b1011, 0, 0, 0, 1'b0);
        idle_cycles(1);
        press(1'b0, 4'b0101, 100, 1, c_BC + 2, 1'b1);
        press(1'b0, 4'b0101, 100, 1, c_BC + 5, 1'b0);
        idle_cycles(1);
        press(1'b0, 4'b1110, 100, 2, c_BC + 20, 1'b0);
        idle_cycles(1);

        // Randomized presses on both instances.
        for (int t = 0; t < 40; t++) begin
            s    = 1'($urandom_range(0, 1));
            h    = $urandom_range(0, 12);
            bc   = s ? 0 : c_BC;
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            at   = $urandom_range(1, 2 * bc + ((h == 0) ? 1 : h));
            press(s, 4'($urandom), h, mode, at, 1'b0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Drives the row side of the 4x4 push-button matrix in response to the scanner's active-low column strobes. It replaces the physical keypad for bench and remote-entry use.
- A controller queues key presses through a valid/ready request. Each press is played out as a timed contact with optional press and release bounce, followed by an inter-key gap.
- Sits between the key-entry controller (or testbench) and the keypad scanner's col/row pins.

Parameters:
- HOLD_W, 16, width of the per-request hold-time field.
- BOUNCE_CYCLES, 8, clock cycles of bounce at press and at release; 0 disables bounce.
- BOUNCE_PERIOD, 2, cycles per bounce half-period (minimum 1).
- GAP_CYCLES, 4, cycles of guaranteed open contact after release; values below 1 are treated as 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- col  input  4  column strobes from the scanner, active-low, nominally one-hot zero.
- row  output  4  row lines to the scanner, active-low; 4'b1111 when no contact.
- req_valid  input  1  key request valid.
- req_ready  output  1  emulator idle and able to accept a request.
- req_key  input  4  key index: column c = req_key[3:2], row r = req_key[1:0].
- req_hold  input  HOLD_W  closed-contact cycles; 0 is treated as 1.
- cancel  input  1  abort the current press.
- busy  output  1  press sequence in progress.
- contact  output  1  internal switch state (1 = closed), for debug.
- done  output  1  one-cycle pulse when a sequence completes or a cancel completes.

Behaviour:
- Reset (async):
  - State goes to IDLE; counter is cleared; latched key is 0.
  - contact=0, row=4'b1111, busy=0, done=0, req_ready=1.
  - Applies immediately even in the middle of a sequence, so the contact opens with no glitch to a closed state.
- row is combinational: row[i] = 0 only when contact=1, col[c]=0 and i=r; otherwise 1.
  - Only col[c] is examined; other column bits are ignored.
  - One key at a time; no ghosting is modelled.
- req_ready = (state==IDLE). A request is accepted on the rising edge where req_valid && req_ready.
  - On acceptance, req_key and max(req_hold,1) are latched.
  - busy=1 from the following cycle.
- States (a single down-counter is reloaded on every state entry):
  - IDLE: contact=0. On accept, go to PRESS_BOUNCE, or straight to HOLD if BOUNCE_CYCLES==0.
  - PRESS_BOUNCE: runs BOUNCE_CYCLES cycles. Elapsed index n = 0 .. BOUNCE_CYCLES-1; contact = 1 when (n / BOUNCE_PERIOD) is even, so the first cycle is closed. Then go to HOLD.
  - HOLD: contact=1 for exactly the latched hold count. Then go to RELEASE_BOUNCE, or GAP if BOUNCE_CYCLES==0.
  - RELEASE_BOUNCE: runs BOUNCE_CYCLES cycles; contact = 1 when (n / BOUNCE_PERIOD) is odd, so the first cycle is open. Then go to GAP.
  - GAP: contact=0 for GAP_CYCLES cycles. On the last GAP cycle edge, go to IDLE; done=1 for exactly one cycle and req_ready=1 in that same cycle.
- contact is registered. It first goes to 1 in the cycle immediately after the acceptance edge.
- cancel:
  - In PRESS_BOUNCE, HOLD or RELEASE_BOUNCE: the next state is GAP with a full GAP_CYCLES reload and contact=0 from the next cycle.
  - Ignored in IDLE and in GAP.
- If cancel coincides with an acceptance edge, the acceptance wins and cancel is ignored that cycle.
- Requests presented while busy are neither accepted nor lost: the requester holds req_valid.
- A back-to-back request valid in the done cycle is accepted on that edge.
- Counter width is max(HOLD_W, clog2 of the bounce/gap lengths); no wrap is possible within a state.
- Total busy length = 2*BOUNCE_CYCLES + max(hold,1) + GAP_CYCLES cycles.

Test Plan:
- Reset, then idle with col cycling 1110,1101,1011,0111 -> row=1111 throughout, req_ready=1, busy=0, done=0.
- BOUNCE_CYCLES=0, GAP_CYCLES=4; request key=4'b0110 (c=1, r=2), hold=5 -> contact=1 for exactly 5 cycles starting the cycle after accept. row=1011 only while col=1101, otherwise 1111. done pulses 9 cycles after accept.
- Defaults, key=0, hold=3 -> contact pattern 1,1,0,0,1,1,0,0 | 1,1,1 | 0,0,1,1,0,0,1,1 | 0,0,0,0. busy is high for 23 cycles, then a single done pulse.
- Defaults, hold=0 -> treated as 1: exactly one closed HOLD cycle.
- Cancel asserted 2 cycles into HOLD with hold=100 -> contact=0 next cycle, GAP of 4 cycles, then done. A second request held valid is accepted on the done edge.
- Async reset asserted mid-HOLD between clock edges -> row=1111 and contact=0 immediately. After release of reset: req_ready=1 and no done pulse.
